// File: rtl/ak16_mem_pkg.sv
// ============================================================================
// Module  : ak16_mem_pkg
// Brief   : Shared types and constants for the AK16 unified-memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ak16_mem_pkg;

  // Arbiter FSM: IDLE arbitrates and issues, WAIT runs the read latency.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Which port owns the read currently in flight.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // Default bus widths.
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  // Legal ranges for the timing parameters.
  localparam int LAT_MIN    = 1;
  localparam int LAT_MAX    = 4;
  localparam int STARVE_MIN = 1;
  localparam int STARVE_LIM = 15;

  // Pin a parameter into its legal range so counter widths stay valid.
  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ak16_mem_arbiter.sv
// ============================================================================
// Module  : ak16_mem_arbiter
// Brief   : Single-outstanding arbiter between the IF (read-only) and DM
//           (read/write) ports of a fixed-latency unified memory. DM has
//           priority; a streak counter guarantees IF a win after STARVE_MAX
//           consecutive contested DM grants. IF reads can be flushed.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ak16_mem_arbiter
  import ak16_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  // Instruction-fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // Data-memory port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  // Memory macro
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // Status
  output logic              busy
);

  // Parameters are pinned into range so the narrow counters cannot overflow.
  localparam logic [2:0] c_lat    = 3'(clamp_int(LAT, LAT_MIN, LAT_MAX));
  localparam logic [3:0] c_starve = 4'(clamp_int(STARVE_MAX, STARVE_MIN, STARVE_LIM));

  state_t     r_state;
  owner_t     r_owner;
  logic [2:0] r_cnt;
  logic [3:0] r_streak;
  logic       r_drop;

  logic w_if_eff;
  logic w_idle;
  logic w_dm_win;
  logic w_if_win;
  logic w_done;
  logic w_if_rv;
  logic w_dm_rv;

  // Arbitration: DM wins ties unless IF has been starved STARVE_MAX times.
  always_comb begin
    w_if_eff = if_req & ~if_flush;
    w_idle   = (r_state == IDLE) & ~rst;
    w_dm_win = w_idle & dm_req & ~(w_if_eff & (r_streak == c_starve));
    w_if_win = w_idle & w_if_eff & ~w_dm_win;
    w_done   = (r_state == WAIT) & (r_cnt == 3'd1) & ~rst;
    // A flush in the completion cycle itself also discards the IF data.
    w_if_rv  = w_done & (r_owner == OWN_IF) & ~r_drop & ~if_flush;
    w_dm_rv  = w_done & (r_owner == OWN_DM);
  end

  // Grant, memory-side mux and response outputs; everything idles at zero.
  always_comb begin
    if_gnt    = w_if_win;
    dm_gnt    = w_dm_win;
    mem_en    = w_if_win | w_dm_win;
    mem_we    = w_dm_win & dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_dm_win) begin
      mem_addr = dm_addr;
      if (dm_we) mem_wdata = dm_wdata;
    end else if (w_if_win) begin
      mem_addr = if_addr;
    end
    if_rvalid = w_if_rv;
    dm_rvalid = w_dm_rv;
    if_rdata  = w_if_rv ? mem_rdata : '0;
    dm_rdata  = w_dm_rv ? mem_rdata : '0;
    busy      = (r_state != IDLE);
  end

  // FSM, latency counter, owner/drop tracking and the starvation streak.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_owner  <= OWN_IF;
      r_cnt    <= 3'd0;
      r_streak <= 4'd0;
      r_drop   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_dm_win) begin
            if (w_if_eff && (r_streak != c_starve)) begin
              r_streak <= r_streak + 4'd1;
            end
            // Writes complete in the grant cycle; only reads wait.
            if (!dm_we) begin
              r_owner <= OWN_DM;
              r_cnt   <= c_lat;
              r_drop  <= 1'b0;
              r_state <= WAIT;
            end
          end else if (w_if_win) begin
            r_streak <= 4'd0;
            r_owner  <= OWN_IF;
            r_cnt    <= c_lat;
            r_drop   <= 1'b0;
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (if_flush && (r_owner == OWN_IF)) begin
            r_drop <= 1'b1;
          end
          // The full latency is always consumed, dropped or not.
          if (r_cnt == 3'd1) begin
            r_cnt   <= 3'd0;
            r_drop  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ak16_mem_arbiter.sv
// ============================================================================
// Module  : tb_ak16_mem_arbiter
// Brief   : Directed table-driven bench for ak16_mem_arbiter (LAT=2 main
//           instance, LAT=1 secondary instance sharing the same inputs).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ak16_mem_arbiter;
  import ak16_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, dm_req, dm_we;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;

  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  logic        d1_if_gnt, d1_if_rvalid, d1_dm_gnt, d1_dm_rvalid, d1_mem_en, d1_mem_we, d1_busy;
  logic [15:0] d1_if_rdata, d1_dm_rdata, d1_mem_addr, d1_mem_wdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ak16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  ak16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(d1_if_gnt), .if_rvalid(d1_if_rvalid), .if_rdata(d1_if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(d1_dm_gnt), .dm_rvalid(d1_dm_rvalid), .dm_rdata(d1_dm_rdata),
    .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
    .mem_rdata(mem_rdata), .busy(d1_busy)
  );

  typedef struct {
    logic        ifr;
    logic [15:0] ifa;
    logic        ifl;
    logic        dmr;
    logic        dmw;
    logic [15:0] dma;
    logic [15:0] dmd;
    logic        e_ig;
    logic        e_dg;
    logic        e_irv;
    logic        e_drv;
    logic        e_en;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wd;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic ifr, input logic [15:0] ifa, input logic ifl,
                              input logic dmr, input logic dmw, input logic [15:0] dma,
                              input logic [15:0] dmd, input logic e_ig, input logic e_dg,
                              input logic e_irv, input logic e_drv, input logic e_en,
                              input logic e_we, input logic [15:0] e_addr,
                              input logic [15:0] e_wd, input logic e_busy);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.ifl = ifl; v.dmr = dmr; v.dmw = dmw;
    v.dma = dma; v.dmd = dmd; v.e_ig = e_ig; v.e_dg = e_dg; v.e_irv = e_irv;
    v.e_drv = e_drv; v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr;
    v.e_wd = e_wd; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if_req = v.ifr; if_addr = v.ifa; if_flush = v.ifl;
    dm_req = v.dmr; dm_we = v.dmw; dm_addr = v.dma; dm_wdata = v.dmd;
  endtask

  // Compare the LAT=2 instance against one expected record.
  task automatic check_main(input string tag, input vec_t v);
    chk({tag, ".if_gnt"},    32'(if_gnt),    32'(v.e_ig));
    chk({tag, ".dm_gnt"},    32'(dm_gnt),    32'(v.e_dg));
    chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'(v.e_irv));
    chk({tag, ".dm_rvalid"}, 32'(dm_rvalid), 32'(v.e_drv));
    chk({tag, ".if_rdata"},  32'(if_rdata),  32'(v.e_irv ? mem_rdata : 16'h0));
    chk({tag, ".dm_rdata"},  32'(dm_rdata),  32'(v.e_drv ? mem_rdata : 16'h0));
    chk({tag, ".mem_en"},    32'(mem_en),    32'(v.e_en));
    chk({tag, ".mem_we"},    32'(mem_we),    32'(v.e_we));
    chk({tag, ".mem_addr"},  32'(mem_addr),  32'(v.e_addr));
    chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(v.e_wd));
    chk({tag, ".busy"},      32'(busy),      32'(v.e_busy));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    mem_rdata = mem_rdata + 16'h0111;
  endtask

  task automatic run_row(input string tag, input vec_t v);
    drive(v);
    @(negedge clk);
    check_main(tag, v);
    next_cycle();
  endtask

  initial begin
    vec_t idle0;
    vec_t dmrd, dmwt, dmrv, ifg;

    idle0 = mk(0,16'h0,0, 0,0,16'h0,16'h0, 0,0,0,0,0,0,16'h0,16'h0,0);

    // Single IF read, LAT=2: grant T, rvalid T+2, next grant T+3.
    tbl.push_back(idle0);
    tbl.push_back(mk(1,16'h0010,0, 0,0,16'h0,16'h0, 1,0,0,0,1,0,16'h0010,16'h0,0));
    tbl.push_back(mk(1,16'h0020,0, 0,0,16'h0,16'h0, 0,0,0,0,0,0,16'h0,16'h0,1));
    tbl.push_back(mk(1,16'h0020,0, 0,0,16'h0,16'h0, 0,0,1,0,0,0,16'h0,16'h0,1));
    tbl.push_back(mk(1,16'h0020,0, 0,0,16'h0,16'h0, 1,0,0,0,1,0,16'h0020,16'h0,0));
    tbl.push_back(mk(0,16'h0,0, 0,0,16'h0,16'h0, 0,0,0,0,0,0,16'h0,16'h0,1));
    tbl.push_back(mk(0,16'h0,0, 0,0,16'h0,16'h0, 0,0,1,0,0,0,16'h0,16'h0,1));
    // Contested DM write wins, completes in one cycle; IF follows next cycle.
    tbl.push_back(mk(1,16'h0030,0, 1,1,16'h0004,16'hBEEF, 0,1,0,0,1,1,16'h0004,16'hBEEF,0));
    tbl.push_back(mk(1,16'h0030,0, 0,0,16'h0,16'h0, 1,0,0,0,1,0,16'h0030,16'h0,0));
    tbl.push_back(mk(0,16'h0,0, 0,0,16'h0,16'h0, 0,0,0,0,0,0,16'h0,16'h0,1));
    tbl.push_back(mk(0,16'h0,0, 0,0,16'h0,16'h0, 0,0,1,0,0,0,16'h0,16'h0,1));
    // Starvation: both held, DM reads. Four DM grants, one IF, then DM again.
    dmrd = mk(1,16'h0200,0, 1,0,16'h0100,16'h0, 0,1,0,0,1,0,16'h0100,16'h0,0);
    dmwt = mk(1,16'h0200,0, 1,0,16'h0100,16'h0, 0,0,0,0,0,0,16'h0,16'h0,1);
    dmrv = mk(1,16'h0200,0, 1,0,16'h0100,16'h0, 0,0,0,1,0,0,16'h0,16'h0,1);
    ifg  = mk(1,16'h0200,0, 1,0,16'h0100,16'h0, 1,0,0,0,1,0,16'h0200,16'h0,0);
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(dmrd); tbl.push_back(dmwt); tbl.push_back(dmrv);
    end
    tbl.push_back(ifg);
    tbl.push_back(dmwt);
    tbl.push_back(mk(1,16'h0200,0, 1,0,16'h0100,16'h0, 0,0,1,0,0,0,16'h0,16'h0,1));
    tbl.push_back(dmrd); tbl.push_back(dmwt); tbl.push_back(dmrv);
    // Flush of an in-flight IF read: no rvalid, latency still consumed.
    tbl.push_back(mk(1,16'h0300,0, 0,0,16'h0,16'h0, 1,0,0,0,1,0,16'h0300,16'h0,0));
    tbl.push_back(mk(0,16'h0,1, 0,0,16'h0,16'h0, 0,0,0,0,0,0,16'h0,16'h0,1));
    tbl.push_back(mk(0,16'h0,0, 0,0,16'h0,16'h0, 0,0,0,0,0,0,16'h0,16'h0,1));
    tbl.push_back(mk(1,16'h0040,0, 0,0,16'h0,16'h0, 1,0,0,0,1,0,16'h0040,16'h0,0));
    tbl.push_back(mk(0,16'h0,0, 0,0,16'h0,16'h0, 0,0,0,0,0,0,16'h0,16'h0,1));
    tbl.push_back(mk(0,16'h0,0, 0,0,16'h0,16'h0, 0,0,1,0,0,0,16'h0,16'h0,1));
    // Same-cycle flush blocks an IF request in IDLE.
    tbl.push_back(mk(1,16'h0050,1, 0,0,16'h0,16'h0, 0,0,0,0,0,0,16'h0,16'h0,0));
    tbl.push_back(idle0);
    // DM read ignores flush.
    tbl.push_back(mk(0,16'h0,0, 1,0,16'h0500,16'h0, 0,1,0,0,1,0,16'h0500,16'h0,0));
    tbl.push_back(mk(0,16'h0,1, 0,0,16'h0,16'h0, 0,0,0,0,0,0,16'h0,16'h0,1));
    tbl.push_back(mk(0,16'h0,0, 0,0,16'h0,16'h0, 0,0,0,1,0,0,16'h0,16'h0,1));
    tbl.push_back(idle0);

    // Reset held with both requests active: everything gated low.
    rst = 1'b1;
    mem_rdata = 16'hD000;
    drive(mk(1,16'h0010,0, 1,0,16'h0100,16'h0, 0,0,0,0,0,0,16'h0,16'h0,0));
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_main("reset", mk(1,16'h0010,0, 1,0,16'h0100,16'h0, 0,0,0,0,0,0,16'h0,16'h0,0));
    chk("reset.d1_mem_en", 32'(d1_mem_en), 32'd0);
    next_cycle();
    drive(idle0);
    rst = 1'b0;

    foreach (tbl[i]) run_row($sformatf("row%0d", i), tbl[i]);

    // Reset asserted one cycle into a DM read: read abandoned.
    run_row("rst_mid.grant", mk(0,16'h0,0, 1,0,16'h0600,16'h0, 0,1,0,0,1,0,16'h0600,16'h0,0));
    rst = 1'b1;
    run_row("rst_mid.inrst", mk(0,16'h0,0, 1,0,16'h0600,16'h0, 0,0,0,0,0,0,16'h0,16'h0,0));
    rst = 1'b0;
    for (int k = 0; k < 3; k++) run_row($sformatf("rst_mid.post%0d", k), idle0);
    run_row("rst_mid.new_gnt", mk(0,16'h0,0, 1,0,16'h0700,16'h0, 0,1,0,0,1,0,16'h0700,16'h0,0));
    run_row("rst_mid.new_wait", mk(0,16'h0,0, 0,0,16'h0,16'h0, 0,0,0,0,0,0,16'h0,16'h0,1));
    run_row("rst_mid.new_rv", mk(0,16'h0,0, 0,0,16'h0,16'h0, 0,0,0,1,0,0,16'h0,16'h0,1));

    // LAT=1 instance: back-to-back IF reads, grant every other cycle.
    rst = 1'b1;
    drive(idle0);
    next_cycle();
    rst = 1'b0;
    if_req = 1'b1;
    if_addr = 16'h0800;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("lat1.c%0d.if_gnt", k),    32'(d1_if_gnt),    32'((k % 2) == 0));
      chk($sformatf("lat1.c%0d.if_rvalid", k), 32'(d1_if_rvalid), 32'((k % 2) == 1));
      chk($sformatf("lat1.c%0d.if_rdata", k),  32'(d1_if_rdata),
          32'(((k % 2) == 1) ? mem_rdata : 16'h0));
      chk($sformatf("lat1.c%0d.mem_addr", k),  32'(d1_mem_addr),
          32'(((k % 2) == 0) ? 16'h0800 : 16'h0));
      chk($sformatf("lat1.c%0d.busy", k),      32'(d1_busy),      32'((k % 2) == 1));
      next_cycle();
    end
    drive(idle0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ak16_mem_arbiter.md
# ak16_mem_arbiter

Arbitrates a single-port, fixed-latency unified memory between the pipeline's instruction-fetch port (IF, read-only) and data-memory port (DM, read/write, driven from the MEM stage). One transaction is in flight at a time. DM has priority, with a starvation guard for IF. IF responses can be discarded on pipeline flush. The block sits between the 6-stage core and the memory macro and supplies the grant/valid signals that the core's stall logic consumes.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- LAT, 2, memory read latency in cycles (legal 1..4)
- STARVE_MAX, 4, consecutive contested DM grants before IF is forced a win (legal 1..15)

- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- if_req  in  1  IF read request; held until granted
- if_addr  in  ADDR_W  IF address
- if_flush  in  1  discard any outstanding or same-cycle IF transaction
- if_gnt  out  1  IF request accepted this cycle
- if_rvalid  out  1  IF read data valid
- if_rdata  out  DATA_W  IF read data
- dm_req  in  1  DM request; held until granted
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  DM address
- dm_wdata  in  DATA_W  DM write data
- dm_gnt  out  1  DM request accepted this cycle
- dm_rvalid  out  1  DM read data valid
- dm_rdata  out  DATA_W  DM read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid LAT cycles after the mem_en read cycle
- busy  out  1  read in flight (state is not IDLE)

## Operation
- FSM states:
  - IDLE: arbitrate and issue.
  - WAIT: latency counter running. Write accesses never enter WAIT.
- Arbitration in IDLE. Effective IF request = if_req & ~if_flush.
  - Only one requester active: that requester wins.
  - Both active: DM wins unless streak == STARVE_MAX, in which case IF wins.
- streak counter:
  - Increments on each DM grant made while IF was also requesting (saturates at STARVE_MAX).
  - Clears on every IF grant.
  - Uncontested DM grants leave it unchanged.
- On a grant, mem_en=1 and mem_* are muxed combinationally from the winner; mem_we = dm_we for DM and 0 for IF.
- Read grant: the owner is latched, cnt is loaded with LAT, and the FSM goes to WAIT. cnt decrements each cycle. When cnt reaches 1:
  - the owner's rvalid is asserted and rdata = mem_rdata;
  - the FSM returns to IDLE.
- Write grant: completes in the grant cycle. No rvalid. FSM stays in IDLE.
- Flush:
  - if_flush in any WAIT cycle with owner IF sets a drop flag. On completion, if_rvalid is suppressed, but the full latency is still consumed.
  - DM transactions are unaffected by flush.
- rdata outputs are 0 whenever the matching rvalid is 0.
- Reset (async):
  - state = IDLE; cnt, streak, owner, and drop flag all 0.
  - All grants, rvalids, and mem_en are gated low while rst = 1.
  - A read in flight at reset is abandoned, with no rvalid after release.

## Timing
- Grant is combinational, in the same cycle as the request when the FSM is in IDLE.
- Read issued in cycle T: rvalid in cycle T+LAT. Earliest next grant is T+LAT+1, so read throughput is 1 per LAT+1 cycles.
- Write issued in cycle T: next grant possible in T+1.
- No grant is made in WAIT; requests must stay asserted until granted.
- Outputs after reset release: all 0 until the first request.

## Structure
- Shared package ak16_mem_pkg holds:
  - state enum {IDLE, WAIT};
  - owner enum {OWN_IF, OWN_DM};
  - ADDR_W/DATA_W defaults;
  - LAT and STARVE_MAX legal-range constants.
- Single module, no sub-modules. The grant mux and FSM/counters stay local.

## Test plan
- LAT=2; IF read 0x0010 alone in cycle T -> if_gnt at T, mem_en/addr 0x0010 at T, if_rvalid at T+2 with mem_rdata, next if_gnt no earlier than T+3.
- dm_req write (0x0004, 0xBEEF) and if_req in the same idle cycle -> dm_gnt, mem_we=1, no rvalid; if_gnt on the following cycle.
- STARVE_MAX=4; dm_req and if_req held continuously, DM reads -> 4 DM grants, then 1 IF grant, streak cleared, pattern repeats.
- IF read granted at T, if_flush at T+1 -> if_rvalid stays 0 at T+2; busy deasserts after T+2; next grant at T+3.
- rst asserted at T+1 mid-DM-read -> no dm_rvalid; after release, all outputs 0, and a new DM read completes normally.
- LAT=1 -> back-to-back IF reads granted every 2 cycles; rvalid the cycle after each grant.
